// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial frame transmitter.
// The optional parity state is only used when SERIAL_TX_PARITY_EN is defined.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the final cycle of each bit.
// tick is a flop that is high exactly while the count sits on its last value.
module bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] LAST      = 8'(CLKS_PER_BIT - 1);
    localparam logic       ONE_CYCLE = (CLKS_PER_BIT == 1);

    logic [7:0] timer;

    // With a one-cycle bit every cycle is the last one, so tick never drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
            tick  <= ONE_CYCLE;
        end else if (clr || tick) begin
            timer <= '0;
            tick  <= ONE_CYCLE;
        end else begin
            timer <= timer + 8'd1;
            tick  <= (timer == LAST - 8'd1);
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, 8 data bits LSB first, optional even
// parity (define SERIAL_TX_PARITY_EN), stop bit. Line idles high.
module serial_tx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       ser_out,
    output logic       busy,
    output logic [3:0] bit_idx,
    output logic       done
);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_STOP   = STOP;
`ifdef SERIAL_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = PARITY;
`endif

    logic [2:0] state, state_nx;
    logic [7:0] shreg, shreg_nx;
    logic [3:0] idx_nx;
    logic       ser_nx;
    logic       tick;
    logic       clr;
`ifdef SERIAL_TX_PARITY_EN
    logic       par, par_nx;
`endif

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        idx_nx   = bit_idx;
`ifdef SERIAL_TX_PARITY_EN
        par_nx   = par;
`endif
        case (state)
            ST_IDLE: begin
                if (valid) begin
                    state_nx = ST_START;
                    shreg_nx = data_in;
                    idx_nx   = 4'd0;
`ifdef SERIAL_TX_PARITY_EN
                    par_nx   = ^data_in;
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    state_nx = ST_DATA;
                    idx_nx   = 4'd1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_nx = shreg >> 1;
                    idx_nx   = bit_idx + 4'd1;
                    if (bit_idx == 4'(DATA_BITS)) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_nx = ST_PARITY;
`else
                        state_nx = ST_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_nx = ST_STOP;
                    idx_nx   = bit_idx + 4'd1;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    state_nx = ST_IDLE;
                    idx_nx   = 4'd0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                idx_nx   = 4'd0;
            end
        endcase
    end

    // The line level is decoded from the next state so it changes on the same edge as the FSM.
    always_comb begin
        ser_nx = IDLE_LEVEL;
        case (state_nx)
            ST_START:  ser_nx = START_LEVEL;
            ST_DATA:   ser_nx = shreg_nx[0];
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: ser_nx = par_nx;
`endif
            default:   ser_nx = IDLE_LEVEL;
        endcase
    end

    assign clr   = (state_nx != state) || (state == ST_IDLE);
    assign ready = (state == ST_IDLE);
    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_STOP) && tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            ser_out <= IDLE_LEVEL;
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            bit_idx <= idx_nx;
            ser_out <= ser_nx;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par <= 1'b0;
        end else begin
            par <= par_nx;
        end
    end
`endif

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one instance at 4 clocks per bit, one at 1 clock per bit.
// Follows SERIAL_TX_PARITY_EN so the same bench covers both builds.
module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL4 = 4 * NB;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid4, valid1;
    logic [7:0] din4, din1;
    logic       ready4, ser4, busy4, done4;
    logic       ready1, ser1, busy1, done1;
    logic [3:0] idx4, idx1;

    int checks = 0;
    int errors = 0;

    logic       cap_ser  [0:63];
    logic       cap_done [0:63];
    logic       cap_rdy  [0:63];
    logic       cap_busy [0:63];
    logic [3:0] cap_idx  [0:63];

    serial_tx #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .data_in(din4), .valid(valid4), .ready(ready4),
        .ser_out(ser4), .busy(busy4), .bit_idx(idx4), .done(done4)
    );

    serial_tx #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(din1), .valid(valid1), .ready(ready1),
        .ser_out(ser1), .busy(busy1), .bit_idx(idx1), .done(done1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one accept and records ncyc cycles of outputs; cycle 1 is the first after the accept edge.
    task automatic run_frame(input bit use_one, input logic [7:0] b, input int ncyc);
        if (use_one) begin valid1 = 1'b1; din1 = b; end
        else         begin valid4 = 1'b1; din4 = b; end
        step();
        valid1 = 1'b0;
        valid4 = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            cap_ser[c]  = use_one ? ser1   : ser4;
            cap_done[c] = use_one ? done1  : done4;
            cap_rdy[c]  = use_one ? ready1 : ready4;
            cap_busy[c] = use_one ? busy1  : busy4;
            cap_idx[c]  = use_one ? idx1   : idx4;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            valid4 = 1'($urandom_range(0, 1));
            valid1 = 1'($urandom_range(0, 1));
            din4   = 8'($urandom);
            din1   = 8'($urandom);
            step();
            checks += 2;
            if ({ser4, ready4, busy4, done4, idx4} !== 8'b1100_0000) begin
                errors++;
                $display("[TB] FAIL reset_dut4 got %b required 11000000", {ser4, ready4, busy4, done4, idx4});
            end
            if ({ser1, ready1, busy1, done1, idx1} !== 8'b1100_0000) begin
                errors++;
                $display("[TB] FAIL reset_dut1 got %b required 11000000", {ser1, ready1, busy1, done1, idx1});
            end
        end
        valid4 = 1'b0;
        valid1 = 1'b0;
        rst    = 1'b1;
        step();
    endtask

    task automatic test_frame_a5();
        logic [10:0] exp;
`ifdef SERIAL_TX_PARITY_EN
        exp = 11'h54A;
`else
        exp = 11'h34A;
`endif
        run_frame(1'b0, 8'hA5, FL4 + 1);
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (cap_ser[1 + 4*b + k] !== exp[b]) begin
                    errors++;
                    $display("[TB] FAIL a5_ser cycle %0d got %b required %b", 1 + 4*b + k, cap_ser[1 + 4*b + k], exp[b]);
                end
            end
        end
        for (int c = 1; c <= FL4 + 1; c++) begin
            checks++;
            if (cap_done[c] !== (c == FL4)) begin
                errors++;
                $display("[TB] FAIL a5_done cycle %0d got %b required %b", c, cap_done[c], (c == FL4));
            end
        end
        checks += 5;
        if (cap_rdy[FL4] !== 1'b0 || cap_rdy[FL4 + 1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL a5_ready got %b%b required 01", cap_rdy[FL4], cap_rdy[FL4 + 1]);
        end
        if (cap_busy[2] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL a5_busy got %b required 1", cap_busy[2]);
        end
        if (cap_idx[1] !== 4'd0) begin
            errors++;
            $display("[TB] FAIL a5_idx_start got %0d required 0", cap_idx[1]);
        end
        if (cap_idx[5] !== 4'd1 || cap_idx[33] !== 4'd8) begin
            errors++;
            $display("[TB] FAIL a5_idx_data got %0d/%0d required 1/8", cap_idx[5], cap_idx[33]);
        end
        if (cap_idx[FL4] !== 4'(NB - 1)) begin
            errors++;
            $display("[TB] FAIL a5_idx_stop got %0d required %0d", cap_idx[FL4], NB - 1);
        end
    endtask

`ifdef SERIAL_TX_PARITY_EN
    task automatic test_parity();
        run_frame(1'b0, 8'h07, 45);
        for (int c = 37; c <= 40; c++) begin
            checks++;
            if (cap_ser[c] !== 1'b1 || cap_idx[c] !== 4'd9) begin
                errors++;
                $display("[TB] FAIL parity_bit cycle %0d got ser=%b idx=%0d required ser=1 idx=9", c, cap_ser[c], cap_idx[c]);
            end
        end
        for (int c = 41; c <= 44; c++) begin
            checks++;
            if (cap_ser[c] !== 1'b1 || cap_idx[c] !== 4'd10) begin
                errors++;
                $display("[TB] FAIL parity_stop cycle %0d got ser=%b idx=%0d required ser=1 idx=10", c, cap_ser[c], cap_idx[c]);
            end
        end
        checks += 2;
        if (cap_done[40] !== 1'b0 || cap_done[44] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL parity_done got c40=%b c44=%b required 0 1", cap_done[40], cap_done[44]);
        end
        if (cap_rdy[44] !== 1'b0 || cap_rdy[45] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL parity_ready got %b%b required 01", cap_rdy[44], cap_rdy[45]);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [10:0] exp;
        bit          idle_seen;
`ifdef SERIAL_TX_PARITY_EN
        exp = 11'h478;
`else
        exp = 11'h278;
`endif
        valid4 = 1'b1;
        din4   = 8'h3C;
        step();
        for (int c = 1; c <= FL4 + 2; c++) begin
            cap_ser[c]  = ser4;
            cap_done[c] = done4;
            cap_rdy[c]  = ready4;
            cap_busy[c] = busy4;
            din4 = 8'($urandom);
            step();
        end
        valid4 = 1'b0;
        for (int b = 0; b < NB; b++) begin
            checks++;
            if (cap_ser[3 + 4*b] !== exp[b]) begin
                errors++;
                $display("[TB] FAIL b2b_bit %0d got %b required %b", b, cap_ser[3 + 4*b], exp[b]);
            end
        end
        checks += 4;
        if (cap_done[FL4] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_done got %b required 1", cap_done[FL4]);
        end
        if (cap_rdy[FL4] !== 1'b0 || cap_rdy[FL4 + 1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_ready got %b%b required 01", cap_rdy[FL4], cap_rdy[FL4 + 1]);
        end
        if (cap_ser[FL4 + 1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_idle_gap got %b required 1", cap_ser[FL4 + 1]);
        end
        if (cap_ser[FL4 + 2] !== 1'b0 || cap_busy[FL4 + 2] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_next_start got ser=%b busy=%b required ser=0 busy=1", cap_ser[FL4 + 2], cap_busy[FL4 + 2]);
        end
        idle_seen = 1'b0;
        for (int n = 0; n < 80 && !idle_seen; n++) begin
            if (!busy4) idle_seen = 1'b1;
            else        step();
        end
        checks++;
        if (!idle_seen) begin
            errors++;
            $display("[TB] FAIL b2b_drain got busy=1 required idle within 80 cycles");
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [10:0] exp;
`ifdef SERIAL_TX_PARITY_EN
        exp = 11'h5FE;
`else
        exp = 11'h3FE;
`endif
        valid4 = 1'b1;
        din4   = 8'h00;
        step();
        valid4 = 1'b0;
        for (int i = 0; i < 21; i++) step();
        checks++;
        if (idx4 !== 4'd5 || ser4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_pre got idx=%0d ser=%b required idx=5 ser=0", idx4, ser4);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({ser4, ready4, busy4, done4, idx4} !== 8'b1100_0000) begin
            errors++;
            $display("[TB] FAIL mid_abort got %b required 11000000", {ser4, ready4, busy4, done4, idx4});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (done4 !== 1'b0 || ser4 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mid_hold got done=%b ser=%b required done=0 ser=1", done4, ser4);
            end
        end
        rst = 1'b1;
        step();
        run_frame(1'b0, 8'hFF, FL4 + 1);
        for (int b = 0; b < NB; b++) begin
            checks++;
            if (cap_ser[3 + 4*b] !== exp[b]) begin
                errors++;
                $display("[TB] FAIL mid_ff_bit %0d got %b required %b", b, cap_ser[3 + 4*b], exp[b]);
            end
        end
        checks++;
        if (cap_done[FL4] !== 1'b1 || cap_done[FL4 - 1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_ff_done got %b%b required 01", cap_done[FL4 - 1], cap_done[FL4]);
        end
    endtask

    task automatic test_one_clk_per_bit();
        logic [10:0] exp;
`ifdef SERIAL_TX_PARITY_EN
        exp = 11'h700;
`else
        exp = 11'h300;
`endif
        run_frame(1'b1, 8'h80, NB + 1);
        for (int b = 0; b < NB; b++) begin
            checks++;
            if (cap_ser[1 + b] !== exp[b]) begin
                errors++;
                $display("[TB] FAIL cpb1_ser cycle %0d got %b required %b", 1 + b, cap_ser[1 + b], exp[b]);
            end
        end
        for (int c = 1; c <= NB + 1; c++) begin
            checks++;
            if (cap_done[c] !== (c == NB)) begin
                errors++;
                $display("[TB] FAIL cpb1_done cycle %0d got %b required %b", c, cap_done[c], (c == NB));
            end
        end
        checks++;
        if (cap_rdy[NB] !== 1'b0 || cap_rdy[NB + 1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cpb1_ready got %b%b required 01", cap_rdy[NB], cap_rdy[NB + 1]);
        end
    endtask

    initial begin
        rst    = 1'b0;
        valid4 = 1'b0;
        valid1 = 1'b0;
        din4   = 8'h00;
        din1   = 8'h00;
        $display("[TB] serial_tx bench start, frame bits %0d", NB);
        test_reset();
        test_frame_a5();
`ifdef SERIAL_TX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_reset_mid();
        test_one_clk_per_bit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
